// File: rtl/radar_pkg.sv
// ============================================================================
// Module : radar_pkg
// Brief  : Shared sweep-controller state encoding and servo pulse-width
//          constants used by the sweep controller and the servo PWM stage.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package radar_pkg;

  localparam int unsigned PW_W       = 20;
  localparam int unsigned PW_MIN_DEF = 16000;
  localparam int unsigned PW_MAX_DEF = 66000;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_WAIT    = 2'd2,
    ST_ADVANCE = 2'd3
  } state_e;

endpackage

`default_nettype wire

// File: rtl/cycle_timer.sv
// ============================================================================
// Module : cycle_timer
// Brief  : Clearable, enabled up-counter with a terminal-count compare.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module cycle_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] term_i,
  output logic         done_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done_o = (count_q == term_i);

endmodule

`default_nettype wire

// File: rtl/servo_sweep_ctrl.sv
// ============================================================================
// Module : servo_sweep_ctrl
// Brief  : Steps a servo back and forth between PW_MIN and PW_MAX, settling
//          and requesting one range measurement at each position.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module servo_sweep_ctrl
  import radar_pkg::*;
#(
  parameter int unsigned PW_MIN       = PW_MIN_DEF,
  parameter int unsigned PW_MAX       = PW_MAX_DEF,
  parameter int unsigned PW_STEP      = 500,
  parameter int unsigned SETTLE_CYC   = 2500000,
  parameter int unsigned MEAS_TIMEOUT = 2700000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            meas_done,
  output logic [PW_W-1:0] pulse_width,
  output logic [7:0]      angle_idx,
  output logic            dir,
  output logic            meas_start,
  output logic            meas_timeout,
  output logic            sweep_wrap
);

  localparam int unsigned T_MAX = (SETTLE_CYC > MEAS_TIMEOUT) ? SETTLE_CYC : MEAS_TIMEOUT;
  localparam int unsigned TW    = (T_MAX < 2) ? 1 : $clog2(T_MAX);

  localparam logic [PW_W-1:0] c_pw_min      = PW_W'(PW_MIN);
  localparam logic [PW_W-1:0] c_pw_max      = PW_W'(PW_MAX);
  localparam logic [PW_W-1:0] c_pw_step     = PW_W'(PW_STEP);
  localparam logic [TW-1:0]   c_settle_term = TW'(SETTLE_CYC - 1);
  localparam logic [TW-1:0]   c_meas_term   = TW'(MEAS_TIMEOUT - 1);

  state_e          state_q, state_d;
  logic [PW_W-1:0] pw_q, pw_d;
  logic [7:0]      idx_q, idx_d;
  logic            dir_q, dir_d;
  logic            start_q, start_d;
  logic            tout_q, tout_d;
  logic            wrap_q, wrap_d;

  logic            timer_clr;
  logic            timer_en;
  logic [TW-1:0]   timer_term;
  logic            timer_done;

  logic            at_end;
  logic            step_dir;

  // Reversal happens in the same ADVANCE cycle, so the step uses the new direction.
  assign at_end   = dir_q ? (pw_q == c_pw_min) : (pw_q == c_pw_max);
  assign step_dir = dir_q ^ at_end;

  cycle_timer #(
    .W (TW)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (timer_clr),
    .en_i   (timer_en),
    .term_i (timer_term),
    .done_o (timer_done)
  );

  always_comb begin
    state_d    = state_q;
    pw_d       = pw_q;
    idx_d      = idx_q;
    dir_d      = dir_q;
    start_d    = 1'b0;
    tout_d     = 1'b0;
    wrap_d     = 1'b0;
    timer_clr  = 1'b1;
    timer_en   = 1'b0;
    timer_term = c_settle_term;

    case (state_q)
      ST_IDLE: begin
        if (en) begin
          state_d = ST_SETTLE;
        end
      end

      ST_SETTLE: begin
        timer_clr = 1'b0;
        timer_en  = 1'b1;
        if (!en) begin
          state_d = ST_IDLE;
        end else if (timer_done) begin
          state_d   = ST_WAIT;
          start_d   = 1'b1;
          timer_clr = 1'b1;
        end
      end

      ST_WAIT: begin
        timer_clr  = 1'b0;
        timer_en   = 1'b1;
        timer_term = c_meas_term;
        // meas_done wins over a coincident expiry.
        if (!en) begin
          state_d = ST_IDLE;
        end else if (meas_done) begin
          state_d = ST_ADVANCE;
        end else if (timer_done) begin
          state_d = ST_ADVANCE;
          tout_d  = 1'b1;
        end
      end

      ST_ADVANCE: begin
        dir_d  = step_dir;
        wrap_d = at_end;
        if (step_dir) begin
          pw_d  = pw_q - c_pw_step;
          idx_d = idx_q - 8'd1;
        end else begin
          pw_d  = pw_q + c_pw_step;
          idx_d = idx_q + 8'd1;
        end
        state_d = en ? ST_SETTLE : ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pw_q    <= c_pw_min;
      idx_q   <= 8'd0;
      dir_q   <= 1'b0;
      start_q <= 1'b0;
      tout_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pw_q    <= pw_d;
      idx_q   <= idx_d;
      dir_q   <= dir_d;
      start_q <= start_d;
      tout_q  <= tout_d;
      wrap_q  <= wrap_d;
    end
  end

  assign pulse_width  = pw_q;
  assign angle_idx    = idx_q;
  assign dir          = dir_q;
  assign meas_start   = start_q;
  assign meas_timeout = tout_q;
  assign sweep_wrap   = wrap_q;

endmodule

`default_nettype wire

// File: tb/tb_servo_sweep_ctrl.sv
// ============================================================================
// Module : tb_servo_sweep_ctrl
// Brief  : Directed self-checking bench for servo_sweep_ctrl with a short
//          sweep (100..130 step 10, settle 4, timeout 8).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_servo_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        meas_done;
  logic [19:0] pulse_width;
  logic [7:0]  angle_idx;
  logic        dir;
  logic        meas_start;
  logic        meas_timeout;
  logic        sweep_wrap;

  int n_total = 0;
  int n_bad   = 0;

  servo_sweep_ctrl #(
    .PW_MIN       (100),
    .PW_MAX       (130),
    .PW_STEP      (10),
    .SETTLE_CYC   (4),
    .MEAS_TIMEOUT (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .meas_done    (meas_done),
    .pulse_width  (pulse_width),
    .angle_idx    (angle_idx),
    .dir          (dir),
    .meas_start   (meas_start),
    .meas_timeout (meas_timeout),
    .sweep_wrap   (sweep_wrap)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Returns cycles until the selected pulse is seen; 40 means it never came.
  task automatic wait_pulse(input bit sel_tout, output int n);
    n = 0;
    while (n < 40) begin
      step();
      n++;
      if ((sel_tout ? meas_timeout : meas_start) === 1'b1) break;
    end
  endtask

  // Entered on the first SETTLE cycle of a position; leaves on the next one.
  task automatic do_pos(input int pw, input int idx, input int d, input int wr);
    int n;
    check("pos_pw", pulse_width, pw);
    check("pos_idx", angle_idx, idx);
    check("pos_dir", dir, d);
    check("pos_wrap", sweep_wrap, wr);
    wait_pulse(1'b0, n);
    check("settle_len", n, 4);
    step();
    step();
    meas_done = 1'b1;
    step();
    meas_done = 1'b0;
    check("done_no_tout", meas_timeout, 0);
    step();
  endtask

  initial begin
    int n;
    logic seen;

    rst       = 1'b1;
    en        = 1'b0;
    meas_done = 1'b0;
    step();
    step();
    check("rst_pw", pulse_width, 100);
    check("rst_idx", angle_idx, 0);
    check("rst_dir", dir, 0);
    check("rst_start", meas_start, 0);
    check("rst_tout", meas_timeout, 0);
    check("rst_wrap", sweep_wrap, 0);
    rst = 1'b0;
    step();
    step();
    check("idle_start", meas_start, 0);

    en = 1'b1;
    step();
    do_pos(100, 0, 0, 0);
    do_pos(110, 1, 0, 0);
    do_pos(120, 2, 0, 0);
    do_pos(130, 3, 0, 0);
    do_pos(120, 2, 1, 1);
    do_pos(110, 1, 1, 0);
    do_pos(100, 0, 1, 0);
    do_pos(110, 1, 0, 1);

    // No meas_done: timeout then advance 120 -> 130.
    check("to_pw_before", pulse_width, 120);
    wait_pulse(1'b0, n);
    check("to_settle_len", n, 4);
    wait_pulse(1'b1, n);
    check("to_latency", n, 8);
    check("to_pw_held", pulse_width, 120);
    step();
    check("to_pw_after", pulse_width, 130);
    check("to_idx_after", angle_idx, 3);
    check("to_one_cycle", meas_timeout, 0);

    // meas_done in SETTLE ignored; then meas_done on the expiry cycle.
    meas_done = 1'b1;
    step();
    meas_done = 1'b0;
    wait_pulse(1'b0, n);
    check("settle_done_ignored", n + 1, 4);
    for (int i = 0; i < 7; i++) step();
    meas_done = 1'b1;
    step();
    meas_done = 1'b0;
    check("coinc_no_tout", meas_timeout, 0);
    check("coinc_pw_held", pulse_width, 130);
    step();
    check("coinc_pw", pulse_width, 120);
    check("coinc_dir", dir, 1);
    check("coinc_wrap", sweep_wrap, 1);
    check("coinc_idx", angle_idx, 2);

    // Drop en mid-WAIT at 120 going down.
    wait_pulse(1'b0, n);
    check("drop_settle_len", n, 4);
    step();
    step();
    en = 1'b0;
    step();
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i == 1) meas_done = 1'b1;
      step();
      meas_done = 1'b0;
      seen = seen | meas_start | meas_timeout | sweep_wrap;
    end
    check("idle_no_pulses", seen, 0);
    check("idle_pw", pulse_width, 120);
    check("idle_idx", angle_idx, 2);
    check("idle_dir", dir, 1);

    en = 1'b1;
    step();
    do_pos(120, 2, 1, 0);
    do_pos(110, 1, 1, 0);
    do_pos(100, 0, 1, 0);
    do_pos(110, 1, 0, 1);
    do_pos(120, 2, 0, 0);

    // Reset mid-SETTLE at 130, with en and meas_done both high.
    check("pre_rst_pw", pulse_width, 130);
    step();
    step();
    rst       = 1'b1;
    meas_done = 1'b1;
    step();
    rst       = 1'b0;
    meas_done = 1'b0;
    check("mid_rst_pw", pulse_width, 100);
    check("mid_rst_idx", angle_idx, 0);
    check("mid_rst_dir", dir, 0);
    check("mid_rst_pulses", {29'd0, meas_start, meas_timeout, sweep_wrap}, 0);
    step();
    do_pos(100, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
